servisia_uart_tx: RTL

SERVISIA_UART_TX -- requirements
Module: servisia_uart_tx

---
 rtl/servisia_uart_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/servisia_uart_tx.sv
// Wishbone-attached 8N1 UART transmitter with a small transmit FIFO.
// DATA (adr 0) writes queue a byte; STATUS (adr 1) reads {empty, busy, full}.
module servisia_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wb_adr_i,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  output logic [7:0] wb_rdt_o,
  output logic       wb_ack_o,
  output logic       tx_o
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] PtrOne  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdt_q, rdt_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  logic       access, push, pop, full, empty, busy, baud_end;
  logic [7:0] head;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign busy     = (state_q != StIdle) || !empty;
  assign head     = mem_q[rptr_q[AW-1:0]];
  assign baud_end = (baud_q == BaudMax);

  // Bus side: one wait cycle per access, push on DATA writes, registered read data.
  always_comb begin
    access = wb_stb_i && !ack_q;
    ack_d  = access;
    // full is taken from the current pointers, so a same-cycle pop never frees a slot early
    push   = access && wb_we_i && !wb_adr_i && !full;
    rdt_d  = 8'h00;
    if (access && !wb_we_i && wb_adr_i) rdt_d = {5'b00000, empty, busy, full};
    wptr_d = push ? wptr_q + PtrOne : wptr_q;
    rptr_d = pop ? rptr_q + PtrOne : rptr_q;
  end

  // Transmit FSM next state; tx_d always reflects the bit of the state being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = 16'd0;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any frame and discards queued bytes.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
      rdt_q   <= 8'h00;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // FIFO storage needs no reset; pointers alone define its contents.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wb_dat_i;
  end

  assign tx_o     = tx_q;
  assign wb_ack_o = ack_q;
  assign wb_rdt_o = rdt_q;

endmodule
